// File: rtl/duart_pkg.sv
// Shared constants, FSM state encoding and FIFO entry layout for the DUART serial receiver.
// DUART_RX_PARITY_EN adds a parity error bit to each entry.
package duart_pkg;
  localparam int OSR        = 16;
  localparam int MID_SAMPLE = 7;
  localparam int SUB_W      = $clog2(OSR);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} rx_state_t;

`ifdef DUART_RX_PARITY_EN
  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } rx_entry_t;
`else
  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } rx_entry_t;
`endif

  localparam int ENTRY_W = $bits(rx_entry_t);
endpackage

// File: rtl/duart_sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, head visible combinationally on dout.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module duart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/duart_serial_rx.sv
// 16x oversampled async receiver feeding a FIFO, valid/ready output, CTS_B flow control.
// DUART_RX_PARITY_EN selects 8 data + parity + stop frames instead of 8N1.
module duart_serial_rx
  import duart_pkg::*;
#(
  parameter int TICK_DIV   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CTS_MARGIN = 2,
  parameter int PARITY_ODD = 0
) (
  input  logic                          ECLK,
  input  logic                          RST,
  input  logic                          rxd,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [7:0]                    m_data,
  output logic                          m_ferr,
  output logic                          m_perr,
  output logic                          overrun,
  input  logic                          ovr_clr,
  output logic                          cts_b,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       sync_q;
  logic             rxd_s;
  logic [15:0]      tick_cnt;
  logic             tick, mid;
  rx_state_t        state, state_nxt;
  logic [SUB_W-1:0] sub;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             push, pop, full, empty;
  rx_entry_t        push_entry, head;
  logic [LW-1:0]    free_cnt;

  // Preloaded to idle-high so reset never looks like a start edge.
  always_ff @(posedge ECLK) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rxd};
  end
  assign rxd_s = sync_q[1];

  assign tick = (tick_cnt == 16'(TICK_DIV - 1));
  always_ff @(posedge ECLK) begin
    if (RST)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign mid = tick && (sub == SUB_W'(MID_SAMPLE));

  always_ff @(posedge ECLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE:  if (tick && !rxd_s) state_nxt = START;
      START: if (mid) state_nxt = rxd_s ? IDLE : DATA;
      DATA:
        if (mid && bit_idx == 3'd7) begin
`ifdef DUART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
`ifdef DUART_RX_PARITY_EN
      PARITY: if (mid) state_nxt = STOP;
`endif
      STOP:
        if (mid) begin
          push      = 1'b1;
          state_nxt = rxd_s ? IDLE : BRK;
        end
      BRK:     if (tick && rxd_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ECLK) begin
    if (RST) begin
      sub     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (tick) sub <= (state == IDLE && state_nxt == START) ? '0 : sub + 1'b1;
      if (state == START && mid) bit_idx <= '0;
      if (state == DATA && mid) begin
        shreg   <= {rxd_s, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

`ifdef DUART_RX_PARITY_EN
  logic perr_q;
  always_ff @(posedge ECLK) begin
    if (RST)                        perr_q <= 1'b0;
    else if (state == PARITY && mid) perr_q <= rxd_s ^ (^shreg) ^ PARITY_ODD[0];
  end
  always_comb begin
    push_entry.perr = perr_q;
    push_entry.ferr = ~rxd_s;
    push_entry.data = shreg;
  end
  assign m_perr = head.perr;
`else
  always_comb begin
    push_entry.ferr = ~rxd_s;
    push_entry.data = shreg;
  end
  assign m_perr = 1'b0;
`endif

  assign m_valid = ~empty;
  assign pop     = m_valid & m_ready;
  assign m_data  = head.data;
  assign m_ferr  = head.ferr;

  duart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (ECLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // A dropped frame wins over a same-cycle clear so no loss goes unreported.
  always_ff @(posedge ECLK) begin
    if (RST)                      overrun <= 1'b0;
    else if (push && full && !pop) overrun <= 1'b1;
    else if (ovr_clr)              overrun <= 1'b0;
  end

  assign free_cnt = LW'(FIFO_DEPTH) - level;
  always_ff @(posedge ECLK) begin
    if (RST) cts_b <= 1'b1;
    else     cts_b <= (free_cnt <= LW'(CTS_MARGIN));
  end
endmodule
